// File: rtl/bp_cce_mode_ctrl.sv
// CCE mode controller: drains in-flight work before switching between uncached and normal modes,
// and tracks outstanding memory commands with a saturating credit counter.
module bp_cce_mode_ctrl #(
    parameter int unsigned mem_credits_p = 8,
    parameter bit          reset_mode_p  = 1'b0
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 cfg_mode_i,
    input  logic                                 unit_busy_i,
    input  logic                                 lce_cmd_v_i,
    input  logic                                 mem_cmd_v_i,
    input  logic                                 mem_cmd_ready_i,
    input  logic                                 mem_resp_v_i,
    input  logic                                 mem_resp_yumi_i,
    output logic                                 mode_o,
    output logic                                 req_gate_o,
    output logic                                 mem_cmd_gate_o,
    output logic [$clog2(mem_credits_p+1)-1:0]   credits_o,
    output logic                                 switching_o,
    output logic                                 error_o
);

    localparam int unsigned CredW = $clog2(mem_credits_p + 1);
    localparam logic [CredW-1:0] MaxCred = CredW'(mem_credits_p);

    typedef enum logic [1:0] {StReady, StDrain, StSwitch} state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             target_q, target_d;
    logic             err_q, err_d;
    logic [CredW-1:0] cred_q, cred_d;
    logic             inc, dec;

    assign inc = mem_cmd_v_i & mem_cmd_ready_i;
    assign dec = mem_resp_v_i & mem_resp_yumi_i;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        case (state_q)
            StReady: begin
                if (cfg_mode_i != mode_q) begin
                    target_d = cfg_mode_i;
                    state_d  = StDrain;
                end
            end
            StDrain: begin
                if ((cred_q == '0) && !unit_busy_i && !lce_cmd_v_i) begin
                    state_d = StSwitch;
                end
            end
            StSwitch: begin
                mode_d  = target_q;
                state_d = StReady;
            end
            default: state_d = StReady;
        endcase
    end

    // Simultaneous inc and dec cancel, so they never saturate or flag an error.
    always_comb begin
        cred_d = cred_q;
        err_d  = err_q;
        if (inc && !dec) begin
            if (cred_q == MaxCred) begin
                err_d = 1'b1;
            end else begin
                cred_d = cred_q + CredW'(1);
            end
        end else if (dec && !inc) begin
            if (cred_q == '0) begin
                err_d = 1'b1;
            end else begin
                cred_d = cred_q - CredW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StReady;
            mode_q   <= reset_mode_p;
            target_q <= reset_mode_p;
            cred_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            cred_q   <= cred_d;
            err_q    <= err_d;
        end
    end

    assign mode_o         = mode_q;
    assign req_gate_o     = (state_q != StReady);
    assign switching_o    = (state_q != StReady);
    assign credits_o      = cred_q;
    assign mem_cmd_gate_o = (cred_q == MaxCred);
    assign error_o        = err_q;

endmodule

// File: tb/tb_bp_cce_mode_ctrl.sv
// Bench for bp_cce_mode_ctrl: two instances (8 credits / reset mode 0, 2 credits / reset mode 1)
// share stimulus; a per-instance behavioural model is checked every cycle.
module tb_bp_cce_mode_ctrl;

    logic clk;
    logic rst, cfg, busy, lce, cmdv, cmdr, respv, respy;

    logic       a_mode, a_req_gate, a_cmd_gate, a_sw, a_err;
    logic [3:0] a_cred;
    logic       b_mode, b_req_gate, b_cmd_gate, b_sw, b_err;
    logic [1:0] b_cred;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bp_cce_mode_ctrl #(.mem_credits_p(8), .reset_mode_p(1'b0)) dut_a (
        .clk_i(clk), .reset_i(rst), .cfg_mode_i(cfg), .unit_busy_i(busy), .lce_cmd_v_i(lce),
        .mem_cmd_v_i(cmdv), .mem_cmd_ready_i(cmdr), .mem_resp_v_i(respv),
        .mem_resp_yumi_i(respy), .mode_o(a_mode), .req_gate_o(a_req_gate),
        .mem_cmd_gate_o(a_cmd_gate), .credits_o(a_cred), .switching_o(a_sw), .error_o(a_err)
    );

    bp_cce_mode_ctrl #(.mem_credits_p(2), .reset_mode_p(1'b1)) dut_b (
        .clk_i(clk), .reset_i(rst), .cfg_mode_i(cfg), .unit_busy_i(busy), .lce_cmd_v_i(lce),
        .mem_cmd_v_i(cmdv), .mem_cmd_ready_i(cmdr), .mem_resp_v_i(respv),
        .mem_resp_yumi_i(respy), .mode_o(b_mode), .req_gate_o(b_req_gate),
        .mem_cmd_gate_o(b_cmd_gate), .credits_o(b_cred), .switching_o(b_sw), .error_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = waiting for quiescence, 2 = applying new mode.
    int cap[2]     = '{8, 2};
    int rmode[2]   = '{0, 1};
    int m_phase[2];
    int m_mode[2];
    int m_target[2];
    int m_cred[2];
    int m_err[2];

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_phase[i]  = 0;
                m_mode[i]   = rmode[i];
                m_target[i] = rmode[i];
                m_cred[i]   = 0;
                m_err[i]    = 0;
            end else begin
                int nc;
                if (m_phase[i] == 0) begin
                    if (int'(cfg) != m_mode[i]) begin
                        m_target[i] = int'(cfg);
                        m_phase[i]  = 1;
                    end
                end else if (m_phase[i] == 1) begin
                    if (m_cred[i] == 0 && !busy && !lce) m_phase[i] = 2;
                end else begin
                    m_mode[i]  = m_target[i];
                    m_phase[i] = 0;
                end
                nc = m_cred[i] + int'(cmdv && cmdr) - int'(respv && respy);
                if (nc < 0) begin
                    nc = 0;
                    m_err[i] = 1;
                end
                if (nc > cap[i]) begin
                    nc = cap[i];
                    m_err[i] = 1;
                end
                m_cred[i] = nc;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_model();
        logic [12:0] act, exp;
        act = {a_mode, a_req_gate, a_sw, a_cmd_gate, a_err, 8'(a_cred)};
        exp = {m_mode[0] != 0, m_phase[0] != 0, m_phase[0] != 0, m_cred[0] == cap[0],
               m_err[0] != 0, 8'(m_cred[0])};
        chk("model dut_a {mode,gate,sw,cgate,err,cred}", int'(act), int'(exp));
        act = {b_mode, b_req_gate, b_sw, b_cmd_gate, b_err, 8'(b_cred)};
        exp = {m_mode[1] != 0, m_phase[1] != 0, m_phase[1] != 0, m_cred[1] == cap[1],
               m_err[1] != 0, 8'(m_cred[1])};
        chk("model dut_b {mode,gate,sw,cgate,err,cred}", int'(act), int'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        check_model();
    endtask

    task automatic set_in(input logic [7:0] v);
        {rst, cfg, busy, lce, cmdv, cmdr, respv, respy} = v;
    endtask

    // in: {rst,cfg,busy,lce,cmdv,cmdr,respv,respy}; exp (dut_a): {mode,gate,cgate,err,cred[3:0]}
    typedef struct {
        logic [7:0] in;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'b1000_0000, 8'b0000_0000};
        tbl[1]  = '{8'b0000_1100, 8'b0000_0001};
        tbl[2]  = '{8'b0000_1000, 8'b0000_0001};
        tbl[3]  = '{8'b0000_1111, 8'b0000_0001};
        tbl[4]  = '{8'b0000_0011, 8'b0000_0000};
        tbl[5]  = '{8'b0110_0000, 8'b0100_0000};
        tbl[6]  = '{8'b0110_1100, 8'b0100_0001};
        tbl[7]  = '{8'b0001_0011, 8'b0100_0000};
        tbl[8]  = '{8'b0000_0000, 8'b0100_0000};
        tbl[9]  = '{8'b0000_0000, 8'b1000_0000};
        tbl[10] = '{8'b0000_0000, 8'b1100_0000};
        tbl[11] = '{8'b0000_0000, 8'b1100_0000};
        tbl[12] = '{8'b0000_0000, 8'b0000_0000};
        tbl[13] = '{8'b0000_0011, 8'b0001_0000};
        tbl[14] = '{8'b0000_0000, 8'b0001_0000};
        tbl[15] = '{8'b1000_0000, 8'b0000_0000};

        set_in(8'b1000_0000);
        step();
        chk("reset req_gate", int'(a_req_gate), 0);
        chk("reset cmd_gate", int'(a_cmd_gate), 0);
        chk("reset mode_b", int'(b_mode), 1);

        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].in);
            step();
            chk($sformatf("vec%0d", i), int'({a_mode, a_req_gate, a_cmd_gate, a_err, a_cred}),
                int'(tbl[i].exp));
        end

        // Minimum switch latency from an idle, drained machine.
        set_in(8'b1000_0000); step();
        set_in(8'b0000_0000);
        for (int i = 0; i < 8; i++) step();
        set_in(8'b0100_0000);
        step();
        chk("lat t+1 req_gate", int'(a_req_gate), 1);
        chk("lat t+1 mode", int'(a_mode), 0);
        step();
        chk("lat t+2 switching", int'(a_sw), 1);
        chk("lat t+2 mode", int'(a_mode), 0);
        step();
        chk("lat t+3 mode", int'(a_mode), 1);
        chk("lat t+3 req_gate", int'(a_req_gate), 0);

        // Drain waits for all outstanding memory responses.
        set_in(8'b1000_0000); step();
        set_in(8'b0000_1100);
        for (int i = 0; i < 3; i++) step();
        chk("drain credits=3", int'(a_cred), 3);
        set_in(8'b0100_0000); step();
        chk("drain entered", int'(a_req_gate), 1);
        set_in(8'b0100_0011);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("drain hold resp%0d mode", i), int'(a_mode), 0);
            chk($sformatf("drain hold resp%0d gate", i), int'(a_req_gate), 1);
        end
        set_in(8'b0100_0000); step();
        chk("switch credits", int'(a_cred), 0);
        chk("switch mode not yet", int'(a_mode), 0);
        step();
        chk("switch done mode", int'(a_mode), 1);
        chk("switch done gate", int'(a_req_gate), 0);

        // Credit saturation on the 2-credit instance.
        set_in(8'b1000_0000); step();
        set_in(8'b0100_1100); step(); step();
        chk("b full credits", int'(b_cred), 2);
        chk("b full cmd_gate", int'(b_cmd_gate), 1);
        set_in(8'b0100_0011); step();
        chk("b after resp credits", int'(b_cred), 1);
        chk("b after resp cmd_gate", int'(b_cmd_gate), 0);
        set_in(8'b0100_1111); step();
        chk("b inc+dec credits", int'(b_cred), 1);
        chk("b inc+dec err", int'(b_err), 0);
        set_in(8'b0100_1100); step(); step();
        chk("b overflow credits", int'(b_cred), 2);
        chk("b overflow err", int'(b_err), 1);

        // Reset during SWITCH abandons the pending target.
        set_in(8'b1000_0000); step();
        set_in(8'b0100_0000); step(); step();
        chk("abort in switch", int'(a_sw), 1);
        set_in(8'b1100_0000); step();
        chk("abort mode", int'(a_mode), 0);
        chk("abort gate", int'(a_req_gate), 0);

        // cfg toggling during a long drain is ignored; the leftover mismatch is caught after.
        set_in(8'b1000_0000); step();
        set_in(8'b0110_0000); step();
        set_in(8'b0010_0000); step();
        set_in(8'b0110_0000); step();
        set_in(8'b0010_0000); step();
        set_in(8'b0010_0000); step();
        chk("toggle still draining", int'(a_req_gate), 1);
        set_in(8'b0000_0000); step();
        chk("toggle switch mode", int'(a_mode), 0);
        step();
        chk("toggle mode=1", int'(a_mode), 1);
        step();
        chk("toggle redrain", int'(a_req_gate), 1);
        step(); step();
        chk("toggle final mode", int'(a_mode), 0);
        chk("toggle final gate", int'(a_req_gate), 0);

        // Randomised traffic against the model.
        set_in(8'b1000_0000); step();
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            cfg   = ($urandom_range(0, 15) == 0) ? ~cfg : cfg;
            busy  = ($urandom_range(0, 3) == 0);
            lce   = ($urandom_range(0, 3) == 0);
            cmdv  = 1'($urandom);
            cmdr  = 1'($urandom);
            respv = 1'($urandom);
            respy = 1'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
